sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 114 +++++++++++
 rtl/sw_debounce.sv | 34 +++
 tb/tb_sw_debounce.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and default sizing for the switch debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sw_debounce_pkg;

    // Per-lane qualification states; 2-bit encoding shared by every lane.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_e;

    localparam int NB_SW_DEF      = 4;
    localparam int NB_COUNTER_DEF = 16;
    localparam int N_STABLE_DEF   = 1000;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// One debounce lane: 2-flop synchronizer, qualification FSM, stability counter, edge pulses.
// Latency: a held raw change reaches o_sw N_STABLE+2 clocks after it is first sampled.
// Backpressure: none; free-running, the outputs are registered levels/pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int NB_COUNTER = NB_COUNTER_DEF,
    parameter int N_STABLE   = N_STABLE_DEF
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw_raw,
    output logic o_sw,
    output logic o_sw_rise,
    output logic o_sw_fall
);

    // Qualification ends when the counter holds this value, so it never wraps.
    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(N_STABLE - 1);

    logic [1:0]            sync_q;
    logic                  s;
    deb_state_e            state_q, state_d;
    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic                  sw_q, sw_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    assign s = sync_q[1];

    // Bring the asynchronous raw level into the clock domain.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_sw_raw};
        end
    end

    // State, counter and output registers; reset aborts any qualification in flight.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: a level must stay unchanged for N_STABLE synced cycles to be accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    sw_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    sw_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_sw      = sw_q;
    assign o_sw_rise = rise_q;
    assign o_sw_fall = fall_q;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Multi-lane switch debouncer: NB_SW independent lanes with level and edge-pulse outputs.
// Latency: N_STABLE+2 clocks from first sampling of a held raw change to o_sw.
// Backpressure: none; every lane runs freely every clock.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW      = NB_SW_DEF,
    parameter int NB_COUNTER = NB_COUNTER_DEF,
    parameter int N_STABLE   = N_STABLE_DEF
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw_raw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall
);

    // One self-contained lane per switch; no state is shared between lanes.
    for (genvar g = 0; g < NB_SW; g++) begin : g_lane
        sw_debounce_bit #(
            .NB_COUNTER (NB_COUNTER),
            .N_STABLE   (N_STABLE)
        ) u_lane (
            .clock     (clock),
            .i_reset   (i_reset),
            .i_sw_raw  (i_sw_raw[g]),
            .o_sw      (o_sw[g]),
            .o_sw_rise (o_sw_rise[g]),
            .o_sw_fall (o_sw_fall[g])
        );
    end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with N_STABLE=8: stimulus queues expected output events, a monitor pops and compares.
// Latency: every accepted change is expected LAT=N_STABLE+2 clocks after its first sampling edge.
// Backpressure: n/a.
module tb_sw_debounce;

    localparam int NB_SW      = 4;
    localparam int NB_COUNTER = 16;
    localparam int N_STABLE   = 8;
    localparam int LAT        = N_STABLE + 2;

    typedef struct {
        int         cyc;
        logic [3:0] sw;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    logic             clock = 1'b0;
    logic             i_reset;
    logic [NB_SW-1:0] i_sw_raw;
    logic [NB_SW-1:0] o_sw;
    logic [NB_SW-1:0] o_sw_rise;
    logic [NB_SW-1:0] o_sw_fall;

    ev_t        exp_q[$];
    ev_t        e_mon;
    int         cyc      = 0;
    int         n_pass   = 0;
    int         n_checks = 0;
    logic [3:0] last_sw  = 4'h0;
    bit         mon_en   = 1'b0;
    bit         done     = 1'b0;

    sw_debounce #(
        .NB_SW      (NB_SW),
        .NB_COUNTER (NB_COUNTER),
        .N_STABLE   (N_STABLE)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_sw_raw  (i_sw_raw),
        .o_sw      (o_sw),
        .o_sw_rise (o_sw_rise),
        .o_sw_fall (o_sw_fall)
    );

    always #5 clock = ~clock;

    // Rising-edge count; an edge numbered k is observed by the monitor at the following falling edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_ev(input int at, input logic [3:0] sw, input logic [3:0] rise,
                             input logic [3:0] fall);
        ev_t e;
        e.cyc  = at;
        e.sw   = sw;
        e.rise = rise;
        e.fall = fall;
        exp_q.push_back(e);
    endtask

    // Monitor: reset-state checks, and an event whenever o_sw changes or any pulse is high.
    always @(negedge clock) begin
        if (mon_en && !i_reset) begin
            n_checks++;
            if (o_sw === 4'h0 && o_sw_rise === 4'h0 && o_sw_fall === 4'h0)
                n_pass++;
            else
                $display("FAIL reset_state cyc=%0d got sw=%b rise=%b fall=%b want all 0",
                         cyc, o_sw, o_sw_rise, o_sw_fall);
        end
        if (mon_en && (o_sw !== last_sw || o_sw_rise !== 4'h0 || o_sw_fall !== 4'h0)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got sw=%b rise=%b fall=%b want no event",
                         cyc, o_sw, o_sw_rise, o_sw_fall);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.cyc == cyc && o_sw === e_mon.sw && o_sw_rise === e_mon.rise &&
                    o_sw_fall === e_mon.fall)
                    n_pass++;
                else
                    $display("FAIL event got cyc=%0d sw=%b rise=%b fall=%b want cyc=%0d sw=%b rise=%b fall=%b",
                             cyc, o_sw, o_sw_rise, o_sw_fall,
                             e_mon.cyc, e_mon.sw, e_mon.rise, e_mon.fall);
            end
        end
        last_sw = o_sw;
        if (done) begin
            n_checks++;
            if (exp_q.size() == 0)
                n_pass++;
            else
                $display("FAIL missing_events got %0d still pending want 0 (next at cyc=%0d)",
                         exp_q.size(), exp_q[0].cyc);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    // Directed stimulus; each raw change set after edge c is first sampled at edge c+1.
    initial begin
        i_reset  = 1'b0;
        i_sw_raw = 4'hF;
        repeat (2) tick();
        mon_en = 1'b1;
        repeat (3) tick();
        i_sw_raw = 4'h0;
        tick();
        i_reset = 1'b1;
        repeat (5) tick();

        // Lane 0 rises and is held.
        i_sw_raw = 4'b0001;
        expect_ev(cyc + 1 + LAT, 4'b0001, 4'b0001, 4'b0000);
        repeat (15) tick();

        // Lane 1 high for only 5 cycles: rejected.
        i_sw_raw = 4'b0011;
        repeat (5) tick();
        i_sw_raw = 4'b0001;
        repeat (15) tick();

        // Lane 2 chatters, then settles high.
        i_sw_raw = 4'b0101;
        repeat (2) tick();
        i_sw_raw = 4'b0001;
        repeat (2) tick();
        i_sw_raw = 4'b0101;
        repeat (2) tick();
        i_sw_raw = 4'b0001;
        repeat (2) tick();
        i_sw_raw = 4'b0101;
        expect_ev(cyc + 1 + LAT, 4'b0101, 4'b0100, 4'b0000);
        repeat (15) tick();

        // Lane 3 rises, then reset lands 4 cycles into its 1->0 qualification.
        i_sw_raw = 4'b1101;
        expect_ev(cyc + 1 + LAT, 4'b1101, 4'b1000, 4'b0000);
        repeat (15) tick();
        i_sw_raw = 4'b0101;
        repeat (7) tick();
        i_reset  = 1'b0;
        i_sw_raw = 4'b1101;
        expect_ev(cyc, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) tick();
        i_reset = 1'b1;
        expect_ev(cyc + 1 + LAT, 4'b1101, 4'b1101, 4'b0000);
        repeat (15) tick();

        // All lanes low, then all lanes switch together both ways.
        i_sw_raw = 4'h0;
        expect_ev(cyc + 1 + LAT, 4'b0000, 4'b0000, 4'b1101);
        repeat (15) tick();
        i_sw_raw = 4'hF;
        expect_ev(cyc + 1 + LAT, 4'hF, 4'hF, 4'h0);
        repeat (15) tick();
        i_sw_raw = 4'h0;
        expect_ev(cyc + 1 + LAT, 4'h0, 4'h0, 4'hF);
        repeat (15) tick();

        done = 1'b1;
        repeat (3) tick();
    end

endmodule : tb_sw_debounce
